seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit, common-anode 7-segment display on the Nexys3 board.
- Each frame, it captures a coherent snapshot of the display request: enables, mode, text, graphic and dots.
- It then sequences one digit at a time through an ON slot followed by a blanking slot, which suppresses ghosting.
- It sits between the board wishbone register block (or the debug mux) and the FPGA segment/anode pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 30 +++
 rtl/seg_scan_ctrl_if.sv | 25 ++
 rtl/hex7seg_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 117 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared board header for the Nexys3 7-segment display: segment bit order,
// hex glyph table and scan state encodings.
package seg_scan_ctrl_pkg;

    // Bit positions within the {dp,g,f,e,d,c,b,a} segment byte.
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Hex glyphs as {g..a}, 1 = lit.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        S_ON    = 1'b0,
        S_BLANK = 1'b1
    } scan_state_e;

    function automatic logic [6:0] hex7(input logic [3:0] value);
        return HEX7_TABLE[value];
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display request (from the register block or debug mux) and the
// resulting segment/anode pin drive.
interface seg_scan_ctrl_if;

    logic [3:0]  en;
    logic        mode;
    logic [15:0] data_text;
    logic [31:0] data_graphic;
    logic [3:0]  dot;

    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        frame_done;

    modport master (
        output en, mode, data_text, data_graphic, dot,
        input  segment, anode, frame_done
    );

    modport slave (
        input  en, mode, data_text, data_graphic, dot,
        output segment, anode, frame_done
    );

endinterface

// File: rtl/hex7seg_decode.sv
// Combinational hex digit to 7-segment glyph decoder, active-high {g..a}.
module hex7seg_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = hex7(value);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for the 4-digit common-anode display.
// A frame-coherent snapshot of the request is shown one digit at a time,
// each ON slot followed by an all-dark slot to suppress ghosting.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 2000,
    parameter int unsigned CNT_BITS     = $clog2(DIGIT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_ctrl_if.slave bus
);

    localparam logic [CNT_BITS-1:0] BLANK_LOAD = CNT_BITS'(BLANK_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] ON_LOAD    = CNT_BITS'(DIGIT_CYCLES - BLANK_CYCLES - 1);

    scan_state_e         state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [1:0]          digit_q;
    logic [1:0]          digit_next;

    logic [3:0]          snap_en_q;
    logic                snap_mode_q;
    logic [15:0]         snap_text_q;
    logic [31:0]         snap_graphic_q;
    logic [3:0]          snap_dot_q;

    logic                frame_done_q;
    logic [7:0]          segment_q;
    logic [3:0]          anode_q;

    logic [6:0]          hex_seg;
    logic [7:0]          lit_text;
    logic [7:0]          lit_graphic;

    assign digit_next = digit_q + 2'd1;

    hex7seg_decode u_hex7seg_decode (
        .value (snap_text_q[{digit_q, 2'b00} +: 4]),
        .seg   (hex_seg)
    );

    assign lit_graphic = snap_graphic_q[{digit_q, 3'b000} +: 8];

    // Text-mode pattern for the current digit, dp taken from the snapshot.
    always_comb begin
        lit_text                = '0;
        lit_text[SEG_G:SEG_A]   = hex_seg;
        lit_text[SEG_DP]        = snap_dot_q[digit_q];
    end

    // Slot sequencer: blank/ON down-counter, digit rotation and frame snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_BLANK;
            cnt_q          <= BLANK_LOAD;
            digit_q        <= 2'd3;
            snap_en_q      <= '0;
            snap_mode_q    <= 1'b0;
            snap_text_q    <= '0;
            snap_graphic_q <= '0;
            snap_dot_q     <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_BLANK: begin
                    if (cnt_q == '0) begin
                        state_q <= S_ON;
                        digit_q <= digit_next;
                        cnt_q   <= ON_LOAD;
                        // Wrapping to digit 0 marks the frame boundary.
                        if (digit_next == 2'd0) begin
                            snap_en_q      <= bus.en;
                            snap_mode_q    <= bus.mode;
                            snap_text_q    <= bus.data_text;
                            snap_graphic_q <= bus.data_graphic;
                            snap_dot_q     <= bus.dot;
                            frame_done_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_ON: begin
                    if (cnt_q == '0) begin
                        state_q <= S_BLANK;
                        cnt_q   <= BLANK_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Registered pin drive, one cycle behind the sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_q   <= 4'hF;
            segment_q <= 8'hFF;
        end else if (state_q != S_ON || !snap_en_q[digit_q]) begin
            anode_q   <= 4'hF;
            segment_q <= 8'hFF;
        end else begin
            anode_q   <= ~(4'b0001 << digit_q);
            segment_q <= snap_mode_q ? ~lit_graphic : ~lit_text;
        end
    end

    assign bus.segment    = segment_q;
    assign bus.anode      = anode_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a cycle-indexed reference model.
module tb_seg_scan_ctrl;

    localparam int D     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * D;

    localparam logic [6:0] HEX_REF [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int gap = 0;
    int last_dig = -1;

    // Model snapshot of the request for the frame being displayed.
    logic [3:0]  m_en;
    logic        m_mode;
    logic [15:0] m_text;
    logic [31:0] m_graphic;
    logic [3:0]  m_dot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    // Check cycle t against the model, update the model, advance one cycle.
    task automatic step();
        int s;
        int dig;
        int off;
        int cur;
        logic [3:0] ea;
        logic [7:0] es;
        logic [7:0] pat;
        logic       ef;
        ea = 4'hF;
        es = 8'hFF;
        s  = t - B - 1;
        if (s >= 0) begin
            dig = (s / D) % 4;
            off = s % D;
            if (off < D - B && m_en[dig]) begin
                ea[dig] = 1'b0;
                if (m_mode) pat = m_graphic[dig*8 +: 8];
                else        pat = {m_dot[dig], HEX_REF[m_text[dig*4 +: 4]]};
                es = ~pat;
            end
        end
        ef = (t >= B) && ((t - B) % FRAME == 0);
        chk("anode", {28'd0, bus.anode}, {28'd0, ea});
        chk("segment", {24'd0, bus.segment}, {24'd0, es});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, ef});

        chk("one_anode_low", {31'd0, $countones(~bus.anode) <= 1}, 32'd1);
        if (bus.anode == 4'hF) begin
            chk("dark_segment", {24'd0, bus.segment}, 32'hFF);
            gap++;
        end else begin
            cur = 0;
            for (int i = 0; i < 4; i++) if (!bus.anode[i]) cur = i;
            if (last_dig >= 0 && cur != last_dig)
                chk("blank_gap", {31'd0, gap >= B}, 32'd1);
            gap      = 0;
            last_dig = cur;
        end

        if (t >= B - 1 && (t - (B - 1)) % FRAME == 0) begin
            m_en      = bus.en;
            m_mode    = bus.mode;
            m_text    = bus.data_text;
            m_graphic = bus.data_graphic;
            m_dot     = bus.dot;
        end
        @(negedge clk);
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst       = 1'b0;
        t         = 0;
        gap       = 0;
        last_dig  = -1;
        m_en      = '0;
        m_mode    = 1'b0;
        m_text    = '0;
        m_graphic = '0;
        m_dot     = '0;
    endtask

    initial begin
        bus.en           = 4'hF;
        bus.mode         = 1'b0;
        bus.data_text    = 16'h1234;
        bus.data_graphic = 32'h0;
        bus.dot          = 4'h0;

        // Text 1234, all enabled.
        do_reset(3);
        run_to(2);
        chk("t1_pre_anode", {28'd0, bus.anode}, 32'hF);
        run_to(3);
        chk("t1_first_anode", {28'd0, bus.anode}, 32'hE);
        chk("t1_first_seg", {24'd0, bus.segment}, 32'h99);
        run_to(2 * FRAME + 4);

        // Graphic mode.
        bus.mode         = 1'b1;
        bus.data_graphic = 32'h80FF0001;
        do_reset(2);
        run_to(3);
        chk("t2_d0", {24'd0, bus.segment}, 32'hFE);
        run_to(11);
        chk("t2_d1_anode", {28'd0, bus.anode}, 32'hD);
        chk("t2_d1", {24'd0, bus.segment}, 32'hFF);
        run_to(19);
        chk("t2_d2", {24'd0, bus.segment}, 32'h00);
        run_to(27);
        chk("t2_d3", {24'd0, bus.segment}, 32'h7F);
        run_to(FRAME + 4);

        // Partial enables with a decimal point.
        bus.mode      = 1'b0;
        bus.en        = 4'b0101;
        bus.data_text = 16'hAAAA;
        bus.dot       = 4'b0001;
        do_reset(2);
        run_to(3);
        chk("t3_d0", {24'd0, bus.segment}, 32'h08);
        run_to(19);
        chk("t3_d2_anode", {28'd0, bus.anode}, 32'hB);
        chk("t3_d2", {24'd0, bus.segment}, 32'h88);
        run_to(2 * FRAME + 4);

        // Mid-frame data change must wait for the next frame.
        bus.en        = 4'hF;
        bus.dot       = 4'h0;
        bus.data_text = 16'h1234;
        do_reset(2);
        run_to(12);
        bus.data_text = 16'h5678;
        run_to(28);
        chk("t4_old_d3_anode", {28'd0, bus.anode}, 32'h7);
        chk("t4_old_d3", {24'd0, bus.segment}, 32'hF9);
        run_to(28 + FRAME);
        chk("t4_new_d3", {24'd0, bus.segment}, 32'h92);

        // Reset asserted in the middle of an ON slot.
        run_to(68);
        do_reset(1);
        run_to(3);
        chk("t5_first_anode", {28'd0, bus.anode}, 32'hE);
        run_to(FRAME + 4);

        // Randomised request traffic.
        for (int i = 0; i < 50 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.en           = 4'($urandom_range(0, 15));
                bus.mode         = 1'($urandom_range(0, 1));
                bus.data_text    = 16'($urandom);
                bus.data_graphic = $urandom;
                bus.dot          = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
